// File: rtl/dct_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : dct_pkg
// Brief   : Shared widths and FSM state type for the DCT accumulator sequencer.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package dct_pkg;

  localparam int c_prod_w = 23;
  localparam int c_sum_w  = 28;
  localparam int c_res_w  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } dct_state_t;

endpackage
`default_nettype wire

// File: rtl/dct_rndsat.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : dct_rndsat
// Brief   : Round-half-up, arithmetic shift and narrow a 28-bit sum to 16 bits.
//           DCT_ACC_SAT_EN selects clamping; otherwise the result wraps.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module dct_rndsat
  import dct_pkg::*;
#(
  parameter int SHIFT = 8
) (
  input  logic [c_sum_w-1:0] sum_in,
  output logic [c_res_w-1:0] res_out
);

  localparam logic signed [c_sum_w:0] c_half = (c_sum_w+1)'(1) << (SHIFT - 1);

  logic signed [c_sum_w:0] w_rounded;
  logic signed [c_sum_w:0] w_shifted;

  // One guard bit so adding the half-LSB cannot overflow the sum.
  assign w_rounded = $signed({sum_in[c_sum_w-1], sum_in}) + c_half;
  assign w_shifted = w_rounded >>> SHIFT;

`ifdef DCT_ACC_SAT_EN
  localparam logic signed [c_sum_w:0] c_max = (c_sum_w+1)'(32767);
  localparam logic signed [c_sum_w:0] c_min = -(c_sum_w+1)'(32768);

  always_comb begin
    res_out = w_shifted[c_res_w-1:0];
    if (w_shifted > c_max) begin
      res_out = 16'h7FFF;
    end else if (w_shifted < c_min) begin
      res_out = 16'h8000;
    end
  end
`else
  logic w_unused;

  assign res_out  = w_shifted[c_res_w-1:0];
  assign w_unused = ^w_shifted[c_sum_w:c_res_w];
`endif

endmodule
`default_nettype wire

// File: rtl/dct_acc_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : dct_acc_seq
// Brief   : Sequences K signed product terms into an external accumulator and
//           returns the rounded, scaled sum (DCT_ACC_SAT_EN: saturate result).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module dct_acc_seq
  import dct_pkg::*;
#(
  parameter int K     = 23,
  parameter int SHIFT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               prod_valid,
  input  logic               prod_neg,
  input  logic [c_sum_w-1:0] acc_in,
  output logic               acc_en,
  output logic               acc_sub,
  output logic               acc_new1,
  output logic [4:0]         coef_idx,
  output logic               busy,
  output logic [c_res_w-1:0] res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               sign_err
);

  localparam logic [4:0] c_last = 5'(K - 1);

  dct_state_t         r_state;
  dct_state_t         w_state_next;
  logic [4:0]         r_idx;
  logic [c_res_w-1:0] r_res_data;
  logic               r_res_valid;
  logic               r_sign_err;
  logic               w_start_ok;
  logic               w_accept;
  logic               w_handshake;
  logic [c_res_w-1:0] w_rounded;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_ok   = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (prod_valid) begin
          w_accept = 1'b1;
          if (r_idx == c_last) begin
            w_state_next = SETTLE;
          end
        end
      end
      SETTLE: w_state_next = DONE;
      DONE: begin
        if (r_res_valid && res_ready) begin
          w_handshake  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The first term is always a load; the accumulator has no negated load path.
  assign acc_en   = w_accept;
  assign acc_new1 = w_accept && (r_idx == 5'd0);
  assign acc_sub  = w_accept && prod_neg && (r_idx != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= 5'd0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_sign_err  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_idx <= 5'd0;
      end else if (w_accept && (r_idx != c_last)) begin
        r_idx <= r_idx + 5'd1;
      end

      if (r_state == SETTLE) begin
        r_res_data  <= w_rounded;
        r_res_valid <= 1'b1;
      end else if (w_handshake) begin
        r_res_valid <= 1'b0;
      end

      if (w_start_ok) begin
        r_sign_err <= 1'b0;
      end else if (w_accept && (r_idx == 5'd0) && prod_neg) begin
        r_sign_err <= 1'b1;
      end
    end
  end

  dct_rndsat #(
    .SHIFT (SHIFT)
  ) u_rndsat (
    .sum_in  (acc_in),
    .res_out (w_rounded)
  );

  assign coef_idx  = r_idx;
  assign busy      = (r_state != IDLE);
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign sign_err  = r_sign_err;

endmodule
`default_nettype wire

// File: doc/dct_acc_seq.md
DCT_ACC_SEQ -- requirements
Module: dct_acc_seq

Interface
REQ-001 Parameter K, default 23, number of product terms summed per result (2..31).
REQ-002 Parameter SHIFT, default 8, arithmetic right shift applied to the 28-bit sum before output (1..12).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begins one K-term accumulation when sampled high in IDLE.
REQ-006 prod_valid  input  1  multiplier presents a valid 23-bit product this cycle.
REQ-007 prod_neg  input  1  coefficient sign for the current product; 1 means subtract.
REQ-008 acc_in  input  28  registered sum from the accumulator, two's complement.
REQ-009 acc_en  output  1  accumulator enable.
REQ-010 acc_sub  output  1  accumulator subtract select.
REQ-011 acc_new1  output  1  accumulator load-first-term select.
REQ-012 coef_idx  output  5  index of the term currently expected, 0..K-1, for coefficient ROM addressing.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 res_data  output  16  rounded, scaled result, two's complement.
REQ-015 res_valid  output  1  res_data valid; held until accepted.
REQ-016 res_ready  input  1  downstream accepts res_data when high with res_valid.
REQ-017 sign_err  output  1  sticky flag: first term of a run arrived with prod_neg=1.

Function
REQ-018 FSM states IDLE, RUN, SETTLE, DONE; IDLE->RUN on start; RUN->SETTLE on acceptance of term K-1; SETTLE->DONE unconditionally; DONE->IDLE on res_valid&res_ready.
REQ-019 Term accepted in RUN when prod_valid=1; acc_en = (state==RUN) & prod_valid, combinational; 0 in all other states.
REQ-020 acc_new1 = acc_en & (coef_idx==0); acc_sub = acc_en & prod_neg & (coef_idx!=0).
REQ-021 coef_idx resets to 0 on entry to RUN, increments per accepted term, never exceeds K-1; prod_valid low stalls without changing state or index.
REQ-022 First term with prod_neg=1: term loaded as positive (accumulator load cannot negate), sign_err set to 1, run continues.
REQ-023 In SETTLE, acc_in holds the complete sum; result register captures round(acc_in) per REQ-024 on that edge.
REQ-024 Rounding: sum = acc_in + 2^(SHIFT-1) in 29 bits, arithmetic shift right by SHIFT, then narrowed to 16 bits per REQ-032/033.
REQ-025 res_valid high from DONE entry until handshake; res_data stable while res_valid=1.
REQ-026 Latency with prod_valid continuously high: start sampled cycle 0, terms accepted cycles 1..K, SETTLE cycle K+1, res_valid first high cycle K+2.
REQ-027 start ignored when state is not IDLE; start and handshake in the same cycle in DONE: handshake completes, start ignored.
REQ-028 sign_err cleared only by reset or by start accepted in IDLE.

Reset
REQ-029 reset low: state IDLE, coef_idx 0, res_data 0, res_valid 0, sign_err 0, busy 0; acc_en/acc_sub/acc_new1 0.
REQ-030 Reset mid-run aborts: no res_valid produced for the aborted run; first start after release begins a fresh run.
REQ-031 Reset deassertion takes effect at the next rising clk edge; no output glitches from combinational controls while reset low.

Configuration
REQ-032 Macro DCT_ACC_SAT_EN defined: shifted value clamped to 16'h7FFF / 16'h8000 when outside signed 16-bit range.
REQ-033 DCT_ACC_SAT_EN undefined: low 16 bits of the shifted value taken, overflow wraps silently.

Structure
REQ-034 Shared package dct_pkg: product width 23, sum width 28, result width 16, FSM state enum type.
REQ-035 Rounding/narrowing in one combinational sub-module dct_rndsat (28-bit in, SHIFT parameter, 16-bit out), macro-dependent.

Verification
REQ-036 Bench models the 28-bit accumulator (new1 load, else add/sub on en) and a 23-bit product source.
REQ-037 K=23, SHIFT=8, 23 products +100, all prod_neg=0 -> sum 2300, res_data 9, res_valid first in cycle 25.
REQ-038 Alternating signs from term 1 (+100,-100,...) with 23 terms -> sum 100, res_data 0; sign_err 0.
REQ-039 23 products 0x3FFFFF positive -> sum 96468969; with DCT_ACC_SAT_EN res_data 0x7FFF, without it 0xC000.
REQ-040 First term prod_neg=1, prod_valid gaps every 3rd cycle, res_ready held low 5 cycles -> sign_err 1, coef_idx stalls correctly, res_data stable until handshake, extra start in DONE ignored.
REQ-041 reset asserted at term 10 -> all outputs at reset values; subsequent start runs full 23 terms and returns correct result.
